// File: rtl/kbd_bus_master_ring_if.sv
// Device-side byte handshake plus bus master signals for kbd_bus_master_ring.
// irq/ovf exist only when KBD_BUS_IRQ_EN is defined.
interface kbd_bus_master_ring_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int SIZE_W     = 12,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        dev_data;
  logic              dev_valid;
  logic              dev_ready;
  logic              br;
  logic              bg;
  logic [ADDR_W-1:0] a_out;
  logic [SIZE_W-1:0] size_out;
  logic              rw_out;
  logic              ctrl_oe;
  logic              dest_out;
  logic [DATA_W-1:0] d_out;
  logic              d_oe;
  logic              ack_in;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;
`ifdef KBD_BUS_IRQ_EN
  logic              irq;
  logic              ovf;
`endif

  modport master (
    input  dev_data, dev_valid, bg, ack_in,
`ifdef KBD_BUS_IRQ_EN
    output irq, ovf,
`endif
    output dev_ready, br, a_out, size_out, rw_out, ctrl_oe, dest_out,
    output d_out, d_oe, busy, fifo_count
  );

  modport slave (
    output dev_data, dev_valid, bg, ack_in,
`ifdef KBD_BUS_IRQ_EN
    input  irq, ovf,
`endif
    input  dev_ready, br, a_out, size_out, rw_out, ctrl_oe, dest_out,
    input  d_out, d_oe, busy, fifo_count
  );
endinterface

// File: rtl/kbd_bus_master_ring.sv
// Buffers device bytes in a FIFO and writes full bursts as bus master into a wrapping RAM ring.
// Optional IRQ/OVF outputs under KBD_BUS_IRQ_EN.
module kbd_bus_master_ring #(
  parameter int              DATA_W      = 32,
  parameter int              FIFO_DEPTH  = 16,
  parameter int              BURST_BYTES = 4,
  parameter int              ADDR_W      = 16,
  parameter int              SIZE_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              RING_BYTES  = 256
) (
  input  logic                   bus_clk_i,
  input  logic                   rst_i,
  kbd_bus_master_ring_if.master  bus
);
  localparam int BPB   = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_REQ  = 5'b00010,
    S_ADDR = 5'b00100,
    S_XFER = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W:0]   offset_inc;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [DATA_W-1:0] head_dat;
  logic              push, pop;

  assign bus.dev_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push          = bus.dev_valid & bus.dev_ready;
  assign pop           = (state_q == S_XFER) & bus.ack_in;

  always_ff @(posedge bus_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.dev_data;
  end

  // Oldest byte lands in the lowest lane; head only moves on an acked beat, so stalls hold D_OUT.
  always_comb begin
    head_dat = '0;
    for (int i = 0; i < BPB; i++) head_dat[8*i +: 8] = mem_q[rd_ptr_q + PTR_W'(i)];
  end

  always_comb begin
    count_d = count_q;
    if (push) count_d = count_d + 1'b1;
    if (pop)  count_d = count_d - CNT_W'(BPB);
  end

  assign offset_inc = {1'b0, offset_q} + (ADDR_W+1)'(BURST_BYTES);

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    size_d   = size_q;
    case (state_q)
      S_IDLE: if (count_q >= CNT_W'(BURST_BYTES)) state_d = S_REQ;
      S_REQ: begin
        if (bus.bg) begin
          state_d = S_ADDR;
          size_d  = SIZE_W'(BURST_BYTES);
        end
      end
      S_ADDR: state_d = S_XFER;
      S_XFER: begin
        if (bus.ack_in) begin
          size_d = size_q - SIZE_W'(BPB);
          if (size_q == SIZE_W'(BPB)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        offset_d = (offset_inc == (ADDR_W+1)'(RING_BYTES)) ? '0 : offset_inc[ADDR_W-1:0];
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      offset_q <= '0;
      size_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      offset_q <= offset_d;
      size_q   <= size_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(BPB);
    end
  end

  // Control lines stay driven through the data phase; everything is zero outside a transaction.
  always_comb begin
    bus.br       = (state_q == S_REQ) | (state_q == S_ADDR) | (state_q == S_XFER);
    bus.ctrl_oe  = (state_q == S_ADDR) | (state_q == S_XFER);
    bus.dest_out = bus.ctrl_oe;
    bus.rw_out   = bus.ctrl_oe;
    bus.a_out    = bus.ctrl_oe ? (BASE_ADDR + offset_q) : '0;
    bus.size_out = bus.ctrl_oe ? size_q : '0;
    bus.d_oe     = (state_q == S_XFER);
    bus.d_out    = bus.d_oe ? head_dat : '0;
    bus.busy     = (state_q != S_IDLE);
  end

  assign bus.fifo_count = count_q;

`ifdef KBD_BUS_IRQ_EN
  logic ovf_q;

  always_ff @(posedge bus_clk_i) begin
    if (rst_i)                                ovf_q <= 1'b0;
    else if (bus.dev_valid && !bus.dev_ready) ovf_q <= 1'b1;
  end

  assign bus.irq = (state_q == S_DONE);
  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_kbd_bus_master_ring.sv
// Scoreboard bench: a 32-bit and an 8-bit instance, expected addresses and beats queued as bytes are pushed.
module tb_kbd_bus_master_ring;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kbd_bus_master_ring_if #(.DATA_W(32)) bus32 ();
  kbd_bus_master_ring_if #(.DATA_W(8))  bus8  ();

  kbd_bus_master_ring #(.DATA_W(32)) u_dut32 (.bus_clk_i(clk), .rst_i(rst), .bus(bus32));
  kbd_bus_master_ring #(.DATA_W(8))  u_dut8  (.bus_clk_i(clk), .rst_i(rst), .bus(bus8));

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  byte32_q[$];
  logic [31:0] exp_beat32_q[$];
  int          exp_addr32_q[$];
  int          off32 = 0;

  int          byte8_cnt = 0;
  logic [7:0]  exp_beat8_q[$];
  int          exp_addr8_q[$];
  int          off8 = 0;
  int          beats8 = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push32(input logic [7:0] b);
    int n = 0;
    bus32.dev_valid = 1'b1;
    bus32.dev_data  = b;
    while (!bus32.dev_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) check_eq("push32_timeout", 0, 1);
    @(posedge clk); #1;
    bus32.dev_valid = 1'b0;
    byte32_q.push_back(b);
    if (byte32_q.size() == 4) begin
      exp_beat32_q.push_back({byte32_q[3], byte32_q[2], byte32_q[1], byte32_q[0]});
      byte32_q.delete();
      exp_addr32_q.push_back(off32);
      off32 = (off32 + 4) % 256;
    end
  endtask

  task automatic push8(input logic [7:0] b);
    int n = 0;
    bus8.dev_valid = 1'b1;
    bus8.dev_data  = b;
    while (!bus8.dev_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) check_eq("push8_timeout", 0, 1);
    @(posedge clk); #1;
    bus8.dev_valid = 1'b0;
    exp_beat8_q.push_back(b);
    byte8_cnt++;
    if (byte8_cnt % 4 == 0) begin
      exp_addr8_q.push_back(off8);
      off8 = (off8 + 4) % 256;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    byte32_q.delete();
    exp_beat32_q.delete();
    exp_addr32_q.delete();
    off32 = 0;
    @(posedge clk); #1;
  endtask

  task automatic drain32();
    int n = 0;
    while ((exp_addr32_q.size() != 0 || exp_beat32_q.size() != 0 || bus32.busy) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) check_eq("drain32_timeout", 0, 1);
  endtask

  task automatic drain8();
    int n = 0;
    while ((exp_addr8_q.size() != 0 || exp_beat8_q.size() != 0 || bus8.busy) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) check_eq("drain8_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus32.ctrl_oe && !bus32.d_oe) begin
        if (exp_addr32_q.size() == 0) check_eq("addr32_unexpected", 1, 0);
        else begin
          check_eq("a_out32", bus32.a_out, exp_addr32_q.pop_front());
          check_eq("size_out32", bus32.size_out, 32'd4);
          check_eq("rw_dest32", {bus32.rw_out, bus32.dest_out}, 32'd3);
        end
      end
      if (bus32.d_oe && bus32.ack_in) begin
        if (exp_beat32_q.size() == 0) check_eq("beat32_unexpected", 1, 0);
        else check_eq("d_out32", bus32.d_out, exp_beat32_q.pop_front());
      end
      if (bus8.ctrl_oe && !bus8.d_oe) begin
        if (exp_addr8_q.size() == 0) check_eq("addr8_unexpected", 1, 0);
        else begin
          check_eq("a_out8", bus8.a_out, exp_addr8_q.pop_front());
          check_eq("size_out8", bus8.size_out, 32'd4);
        end
      end
      if (bus8.d_oe && bus8.ack_in) begin
        beats8++;
        if (exp_beat8_q.size() == 0) check_eq("beat8_unexpected", 1, 0);
        else check_eq("d_out8", bus8.d_out, exp_beat8_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus32.dev_valid = 1'b0; bus32.dev_data = '0; bus32.bg = 1'b1; bus32.ack_in = 1'b1;
    bus8.dev_valid  = 1'b0; bus8.dev_data  = '0; bus8.bg  = 1'b1; bus8.ack_in  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_br", bus32.br, 0);
    check_eq("rst_busy", bus32.busy, 0);
    check_eq("rst_oe", {bus32.ctrl_oe, bus32.d_oe, bus32.dest_out, bus32.rw_out}, 0);
    check_eq("rst_a_out", bus32.a_out, 0);
    check_eq("rst_size_out", bus32.size_out, 0);
    check_eq("rst_d_out", bus32.d_out, 0);
    check_eq("rst_fifo_count", bus32.fifo_count, 0);
    check_eq("rst_dev_ready", bus32.dev_ready, 1);
    rst = 1'b0;

    // First burst: cycle-by-cycle latency with grant and ack held high.
    for (int i = 0; i < 4; i++) push32(8'h41 + 8'(i));
    check_eq("lat_count4", bus32.fifo_count, 4);
    check_eq("lat_br_before", bus32.br, 0);
    @(posedge clk); #1;
    check_eq("lat_br_req", bus32.br, 1);
    check_eq("lat_no_oe_req", bus32.ctrl_oe, 0);
    @(posedge clk); #1;
    check_eq("lat_addr_phase", {bus32.ctrl_oe, bus32.d_oe}, 32'b10);
    @(posedge clk); #1;
    check_eq("lat_xfer_doe", bus32.d_oe, 1);
    check_eq("lat_xfer_dout", bus32.d_out, 32'h44434241);
    @(posedge clk); #1;
    check_eq("lat_done_busy", bus32.busy, 1);
    check_eq("lat_done_br", bus32.br, 0);
    check_eq("lat_done_count", bus32.fifo_count, 0);
    @(posedge clk); #1;
    check_eq("lat_idle_busy", bus32.busy, 0);

    // 65 more bursts: the address sequence wraps past 0x00FC.
    for (int i = 0; i < 260; i++) push32(8'(i * 7 + 3));
    drain32();
    check_eq("wrap_count", bus32.fifo_count, 0);

    // Grant withheld: request stays up, nothing driven.
    bus32.bg = 1'b0;
    for (int i = 0; i < 6; i++) push32(8'hC0 + 8'(i));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_eq("bghold_br", bus32.br, 1);
      check_eq("bghold_oe", {bus32.ctrl_oe, bus32.d_oe}, 0);
    end
    bus32.bg = 1'b1;
    drain32();
    check_eq("bghold_left", bus32.fifo_count, 2);

    // Reset in the middle of a stalled data phase.
    bus32.ack_in = 1'b0;
    push32(8'hD0);
    push32(8'hD1);
    begin
      int n = 0;
      while (!bus32.d_oe && n < 50) begin @(posedge clk); #1; n++; end
      check_eq("rst_xfer_reached", bus32.d_oe, 1);
    end
    do_reset();
    check_eq("midrst_br_busy", {bus32.br, bus32.busy}, 0);
    check_eq("midrst_oe", {bus32.ctrl_oe, bus32.d_oe, bus32.dest_out, bus32.rw_out}, 0);
    check_eq("midrst_a_out", bus32.a_out, 0);
    check_eq("midrst_d_out", bus32.d_out, 0);
    check_eq("midrst_count", bus32.fifo_count, 0);
    check_eq("midrst_ready", bus32.dev_ready, 1);
    rst = 1'b0;
    bus32.ack_in = 1'b1;
    for (int i = 0; i < 4; i++) push32(8'hA0 + 8'(i));
    drain32();

    // 8-bit bus: beat 2 stalled for three cycles.
    beats8 = 0;
    for (int i = 0; i < 4; i++) push8(8'h41 + 8'(i));
    begin
      int n = 0;
      while (!bus8.d_oe && n < 50) begin @(posedge clk); #1; n++; end
      check_eq("b8_xfer_reached", bus8.d_oe, 1);
    end
    @(posedge clk); #1;
    bus8.ack_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("b8_stall_dout", bus8.d_out, 32'h42);
      check_eq("b8_stall_doe", bus8.d_oe, 1);
      if (c < 2) begin @(posedge clk); #1; end
    end
    bus8.ack_in = 1'b1;
    drain8();
    check_eq("b8_beats", beats8, 4);
    check_eq("b8_count", bus8.fifo_count, 0);

`ifdef KBD_BUS_IRQ_EN
    do_reset();
    check_eq("irq_rst", {bus32.irq, bus32.ovf}, 0);
    rst = 1'b0;
    bus32.bg = 1'b0;
    for (int i = 0; i < 16; i++) push32(8'h50 + 8'(i));
    check_eq("full_ready", bus32.dev_ready, 0);
    check_eq("full_count", bus32.fifo_count, 16);
    check_eq("ovf_before", bus32.ovf, 0);
    bus32.dev_valid = 1'b1;
    bus32.dev_data  = 8'hEE;
    @(posedge clk); #1;
    bus32.dev_valid = 1'b0;
    check_eq("ovf_set", bus32.ovf, 1);
    check_eq("ovf_no_push", bus32.fifo_count, 16);
    bus32.bg = 1'b1;
    begin
      int irqs = 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk); #1;
        if (bus32.irq) irqs++;
      end
      check_eq("irq_pulses", irqs, 4);
    end
    check_eq("ovf_sticky", bus32.ovf, 1);
    drain32();
`endif

    check_eq("sb32_empty", exp_beat32_q.size() + exp_addr32_q.size(), 0);
    check_eq("sb8_empty", exp_beat8_q.size() + exp_addr8_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/kbd_bus_master_ring.md
Name: kbd_bus_master_ring

Overview:
- Parametrised successor of the keyboard bus controller.
- Accepts bytes from a device front-end into an internal FIFO. Once a full burst is buffered, it arbitrates for the shared bus as master and writes the burst to a ring buffer in RAM.
- Ring addresses advance per burst and wrap.
- Sits between the keyboard/device scan logic and the system bus arbiter; bus tristate drivers live one level up.

Parameters:
- DATA_W, 32, bus data width in bits (8, 16 or 32)
- FIFO_DEPTH, 16, device byte FIFO depth (power of 2, >= BURST_BYTES)
- BURST_BYTES, 4, bytes per bus transaction (multiple of DATA_W/8)
- ADDR_W, 16, bus address width
- SIZE_W, 12, bus SIZE field width
- BASE_ADDR, 16'h0000, ring buffer base address
- RING_BYTES, 256, ring length in bytes (multiple of BURST_BYTES)

Ports:
- BUS_CLK  in  1  single clock
- RST  in  1  synchronous, active-high reset
- DEV_DATA  in  8  device byte
- DEV_VALID  in  1  byte offered
- DEV_READY  out  1  FIFO not full
- BR  out  1  bus request to arbiter
- BG  in  1  bus grant
- A_OUT  out  ADDR_W  address to drive
- SIZE_OUT  out  SIZE_W  transfer size to drive
- RW_OUT  out  1  1 = write
- CTRL_OE  out  1  enable for A/SIZE/RW tristates
- DEST_OUT  out  1  selects RAM as slave
- D_OUT  out  DATA_W  write data
- D_OE  out  1  data tristate enable
- ACK_IN  in  1  slave acknowledge / beat accept
- BUSY  out  1  state != IDLE
- FIFO_COUNT  out  log2(FIFO_DEPTH)+1  bytes buffered

Behaviour:
- Interface: one clock, BUS_CLK; reset RST is synchronous and active-high.
- Reset values (applied on the first rising edge with RST=1, including mid-transfer):
  - BR, CTRL_OE, DEST_OUT, D_OE, RW_OUT, BUSY = 0
  - A_OUT = 0, SIZE_OUT = 0, D_OUT = 0
  - FIFO emptied; FIFO_COUNT = 0; DEV_READY = 1
  - ring offset = 0; state = IDLE
- FIFO:
  - A byte is pushed when DEV_VALID & DEV_READY.
  - DEV_READY = (FIFO_COUNT != FIFO_DEPTH). No drops; the device holds the byte.
  - A push and a pop in the same cycle are both honoured, and the count is adjusted net.
- State machine (one-hot, registered):
  - IDLE: -> REQ when FIFO_COUNT >= BURST_BYTES.
  - REQ: BR = 1. -> ADDR when BG = 1. BR stays high until DONE.
  - ADDR: exactly one cycle. CTRL_OE = 1, DEST_OUT = 1, RW_OUT = 1, SIZE_OUT = BURST_BYTES, A_OUT = BASE_ADDR + offset. -> XFER.
  - XFER:
    - CTRL_OE, DEST_OUT and D_OE = 1.
    - Beat b drives D_OUT from the next DATA_W/8 FIFO bytes, packed little-endian (oldest byte in bits [7:0]).
    - A beat completes on a cycle with ACK_IN = 1: those bytes pop and remaining size decrements by DATA_W/8.
    - ACK_IN = 0 stalls; D_OUT is held unchanged.
    - -> DONE when the last beat is acked. Beats = BURST_BYTES*8/DATA_W.
  - DONE: one cycle. All enables and BR = 0; offset += BURST_BYTES, wrapping to 0 at RING_BYTES. -> IDLE.
- Latency, BG=1 and ACK_IN=1 continuously: BR rises 1 cycle after the threshold is reached; first data beat 2 cycles after BG is sampled.
- BG deasserted before ADDR: remain in REQ. BG is ignored after ADDR.
- The FIFO keeps accepting bytes during a transfer. Popped bytes are only those belonging to the current burst.
- Back-to-back bursts: DONE -> IDLE -> REQ. At least one idle bus cycle between transactions.

Optional Feature:
- Macro KBD_BUS_IRQ_EN.
- Defined:
  - Adds output IRQ (1 bit, reset 0). Pulses 1 cycle in DONE.
  - Adds output OVF (sticky, reset 0). Set when DEV_VALID = 1 while the FIFO is full; cleared only by RST.
- Undefined: no IRQ/OVF ports, and no related logic exists.

Test Plan:
- Default params; push 8'h41,42,43,44; BG and ACK_IN held at 1 -> BR, then ADDR with A_OUT=0000, SIZE_OUT=004, then one beat with D_OUT=32'h44434241; FIFO_COUNT=0; BUSY returns low after DONE.
- 65 bursts of 4 bytes -> A_OUT sequence 0000, 0004, …, 00FC, then 0000 (wrap).
- DATA_W=8; push 4 bytes; ACK_IN low on beat 2 for 3 cycles -> D_OUT holds 8'h42 for those cycles; 4 beats total; SIZE_OUT=004.
- BG held 0 for 10 cycles with 6 bytes buffered -> BR stays 1 and no OE asserts. Once BG is released, 4 bytes are sent and FIFO_COUNT=2.
- RST asserted during XFER -> next cycle all outputs at reset values; FIFO_COUNT=0; the following burst starts at A_OUT=0000.
- KBD_BUS_IRQ_EN defined; 17 pushes with BG=0 -> DEV_READY=0 at 16 and OVF=1. Granting the bus then gives one IRQ pulse per burst.
